// File: rtl/multi_cycle_control_unit.sv
// Control FSM for a multi-cycle RV32I-subset core: one state per micro-step,
// datapath selects and load enables decoded from the current state.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | post-reset bubble, all outputs low
// FETCH      | read instruction at PC, PC <= PC+4 when the bus completes
// DECODE     | ALUOut <= oldPC + imm (branch target), dispatch on opcode
// MEM_ADDR   | ALUOut <= rs1 + imm (effective address)
// MEM_READ   | load data access at ALUOut
// MEM_WB     | register file <= memory data
// MEM_WRITE  | store data access at ALUOut
// EXEC_R     | rs1 op rs2
// EXEC_I     | rs1 op imm
// ALU_WB     | register file <= ALUOut
// BRANCH     | compare rs1/rs2, PC <= target on BEQ/BNE taken
// JAL        | ALUOut <= oldPC+4 (link), PC <= target
// LUI        | ALUOut <= 0 + imm
// FAULT      | sticky error, absorbing until reset
module multi_cycle_control_unit #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic       o_mem_req,
    output logic       o_mem_write,
    output logic       o_iord,
    output logic       o_ir_write,
    output logic       o_pc_write,
    output logic       o_reg_write,
    output logic [1:0] o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_alu_op,
    output logic [1:0] o_result_src,
    output logic       o_retire,
    output logic       o_fault,
    output logic [3:0] o_state
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXEC_R    = 4'd7,
        S_EXEC_I    = 4'd8,
        S_ALU_WB    = 4'd9,
        S_BRANCH    = 4'd10,
        S_JAL       = 4'd11,
        S_LUI       = 4'd12,
        S_FAULT     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam int CNT_W  = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam int TC_INT = (MEM_TIMEOUT < 1) ? 0 : MEM_TIMEOUT - 1;
    localparam logic [CNT_W-1:0] WAIT_TC = CNT_W'(TC_INT);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             w_wait_state;
    logic             w_timeout;
    logic             w_unused;

    // funct7[5] only matters to the ALU decoder, which sits outside this block
    assign w_unused = i_funct7_5;

    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_READ) ||
                          (r_state == S_MEM_WRITE);
    // r_wait_cnt holds the stall cycles already spent; this is the last allowed one
    assign w_timeout    = !i_mem_ready && (r_wait_cnt == WAIT_TC);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_wait_state && !i_mem_ready) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_next = S_FAULT;
        case (r_state)
            S_IDLE:      w_next = S_FETCH;
            S_FETCH: begin
                if (i_mem_ready)    w_next = S_DECODE;
                else if (w_timeout) w_next = S_FAULT;
                else                w_next = S_FETCH;
            end
            S_DECODE: begin
                case (i_opcode)
                    OP_LOAD, OP_STORE: w_next = S_MEM_ADDR;
                    OP_R:              w_next = S_EXEC_R;
                    OP_I:              w_next = S_EXEC_I;
                    OP_BRANCH:         w_next = S_BRANCH;
                    OP_JAL:            w_next = S_JAL;
                    OP_LUI:            w_next = S_LUI;
                    default:           w_next = S_FAULT;
                endcase
            end
            S_MEM_ADDR: begin
                if (i_funct3 != 3'b010)       w_next = S_FAULT;
                else if (i_opcode == OP_LOAD)  w_next = S_MEM_READ;
                else if (i_opcode == OP_STORE) w_next = S_MEM_WRITE;
                else                           w_next = S_FAULT;
            end
            S_MEM_READ: begin
                if (i_mem_ready)    w_next = S_MEM_WB;
                else if (w_timeout) w_next = S_FAULT;
                else                w_next = S_MEM_READ;
            end
            S_MEM_WB:    w_next = S_FETCH;
            S_MEM_WRITE: begin
                if (i_mem_ready)    w_next = S_FETCH;
                else if (w_timeout) w_next = S_FAULT;
                else                w_next = S_MEM_WRITE;
            end
            S_EXEC_R:    w_next = S_ALU_WB;
            S_EXEC_I:    w_next = S_ALU_WB;
            S_ALU_WB:    w_next = S_FETCH;
            S_BRANCH: begin
                if (i_funct3 == 3'b000 || i_funct3 == 3'b001) w_next = S_FETCH;
                else                                          w_next = S_FAULT;
            end
            S_JAL:       w_next = S_ALU_WB;
            S_LUI:       w_next = S_ALU_WB;
            S_FAULT:     w_next = S_FAULT;
            default:     w_next = S_FAULT;
        endcase
    end

    always_comb begin
        o_mem_req    = 1'b0;
        o_mem_write  = 1'b0;
        o_iord       = 1'b0;
        o_ir_write   = 1'b0;
        o_pc_write   = 1'b0;
        o_reg_write  = 1'b0;
        o_alu_src_a  = 2'b00;
        o_alu_src_b  = 2'b00;
        o_alu_op     = 2'b00;
        o_result_src = 2'b00;
        o_retire     = 1'b0;
        o_fault      = 1'b0;
        case (r_state)
            S_FETCH: begin
                o_mem_req    = 1'b1;
                o_alu_src_b  = 2'b10;
                o_result_src = 2'b10;
                o_ir_write   = i_mem_ready;
                o_pc_write   = i_mem_ready;
            end
            S_DECODE: begin
                o_alu_src_a = 2'b01;
                o_alu_src_b = 2'b01;
            end
            S_MEM_ADDR: begin
                o_alu_src_a = 2'b10;
                o_alu_src_b = 2'b01;
            end
            S_MEM_READ: begin
                o_mem_req = 1'b1;
                o_iord    = 1'b1;
            end
            S_MEM_WB: begin
                o_reg_write  = 1'b1;
                o_result_src = 2'b01;
                o_retire     = 1'b1;
            end
            S_MEM_WRITE: begin
                o_mem_req   = 1'b1;
                o_mem_write = 1'b1;
                o_iord      = 1'b1;
                o_retire    = i_mem_ready;
            end
            S_EXEC_R: begin
                o_alu_src_a = 2'b10;
                o_alu_op    = 2'b10;
            end
            S_EXEC_I: begin
                o_alu_src_a = 2'b10;
                o_alu_src_b = 2'b01;
                o_alu_op    = 2'b10;
            end
            S_ALU_WB: begin
                o_reg_write = 1'b1;
                o_retire    = 1'b1;
            end
            S_BRANCH: begin
                o_alu_src_a = 2'b10;
                o_alu_op    = 2'b01;
                if (i_funct3 == 3'b000) begin
                    o_pc_write = i_zero;
                    o_retire   = 1'b1;
                end else if (i_funct3 == 3'b001) begin
                    o_pc_write = !i_zero;
                    o_retire   = 1'b1;
                end
            end
            S_JAL: begin
                o_alu_src_a = 2'b01;
                o_alu_src_b = 2'b10;
                o_pc_write  = 1'b1;
            end
            S_LUI: begin
                o_alu_src_a = 2'b11;
                o_alu_src_b = 2'b01;
            end
            S_FAULT: o_fault = 1'b1;
            default: ;
        endcase
    end

    assign o_state = r_state;

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Scoreboard bench for multi_cycle_control_unit: stimulus pushes the expected
// retire/fault event, a negedge monitor pops and compares when the DUT presents it.
module tb_multi_cycle_control_unit;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       mem_ready;
    logic       o_mem_req, o_mem_write, o_iord, o_ir_write, o_pc_write, o_reg_write;
    logic [1:0] o_alu_src_a, o_alu_src_b, o_alu_op, o_result_src;
    logic       o_retire, o_fault;
    logic [3:0] o_state;
    logic [15:0] outvec;

    typedef struct packed {
        logic [3:0]  st;
        logic        rw;
        logic        pcw;
        logic [1:0]  rs;
        logic        mw;
        logic [15:0] lat;
    } exp_t;

    exp_t scb[$];
    int   n_vec = 0;
    int   n_err = 0;

    multi_cycle_control_unit #(.MEM_TIMEOUT(255)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_opcode     (opcode),
        .i_funct3     (funct3),
        .i_funct7_5   (funct7_5),
        .i_zero       (zero),
        .i_mem_ready  (mem_ready),
        .o_mem_req    (o_mem_req),
        .o_mem_write  (o_mem_write),
        .o_iord       (o_iord),
        .o_ir_write   (o_ir_write),
        .o_pc_write   (o_pc_write),
        .o_reg_write  (o_reg_write),
        .o_alu_src_a  (o_alu_src_a),
        .o_alu_src_b  (o_alu_src_b),
        .o_alu_op     (o_alu_op),
        .o_result_src (o_result_src),
        .o_retire     (o_retire),
        .o_fault      (o_fault),
        .o_state      (o_state)
    );

    // bit order: mem_req mem_write iord ir_write pc_write reg_write a[1:0] b[1:0] op[1:0] rs[1:0] retire fault
    assign outvec = {o_mem_req, o_mem_write, o_iord, o_ir_write, o_pc_write, o_reg_write,
                     o_alu_src_a, o_alu_src_b, o_alu_op, o_result_src, o_retire, o_fault};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] st, input logic rw, input logic pcw,
                                input logic [1:0] rs, input logic mw, input int lat);
        exp_t e;
        e.st = st; e.rw = rw; e.pcw = pcw; e.rs = rs; e.mw = mw; e.lat = 16'(lat);
        return e;
    endfunction

    // monitor: latency counts cycles from FETCH entry to the event cycle inclusive
    int         mon_lat = 0;
    logic [3:0] mon_prev_st = 4'd0;
    logic       mon_prev_fault = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            mon_lat = 0;
            mon_prev_st = 4'd0;
            mon_prev_fault = 1'b0;
        end else begin
            if (o_state == 4'd1 && mon_prev_st != 4'd1) mon_lat = 1;
            else mon_lat = mon_lat + 1;
            if (o_retire || (o_fault && !mon_prev_fault)) begin
                if (scb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_event: state %0d retire %0b fault %0b, expected none",
                             o_state, o_retire, o_fault);
                end else begin
                    e = scb.pop_front();
                    check("event_outputs", {o_state, o_reg_write, o_pc_write, o_result_src, o_mem_write},
                          {e.st, e.rw, e.pcw, e.rs, e.mw});
                    check("event_latency", mon_lat, e.lat);
                end
            end
            mon_prev_st = o_state;
            mon_prev_fault = o_fault;
        end
    end

    // Entered in a FETCH cycle; returns in the next FETCH cycle (or in FAULT when e.st==15)
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                             input logic [3:0] wait_st, input int waits, input exp_t e,
                             input logic [3:0] pst, input logic [15:0] pval, input int exp_rd);
        int rd_cnt;
        int left;
        bit probed;
        bit done;
        opcode = op; funct3 = f3; zero = z;
        scb.push_back(e);
        rd_cnt = 0; left = waits; probed = 0; done = 0;
        for (int n = 0; n < 400 && !done; n++) begin
            if (n > 0) begin
                @(posedge clk); #1;
            end
            if (o_state == wait_st && left > 0) begin
                mem_ready = 1'b0;
                left--;
            end else begin
                mem_ready = 1'b1;
            end
            #1;
            if (o_state == pst && !probed) begin
                probed = 1;
                check("state_outputs", {o_state, outvec}, {pst, pval});
            end
            if (o_state == 4'd4 && o_mem_req) rd_cnt++;
            if (e.st == 4'd15) done = (o_state == 4'd15);
            else done = (n > 0 && o_state == 4'd1);
        end
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL instr_timeout: opcode %b stuck in state %0d, expected state %0d", op, o_state,
                     (e.st == 4'd15) ? 15 : 1);
        end
        if (!probed) begin
            n_vec++; n_err++;
            $display("FAIL probe_missing: opcode %b never reached state %0d", op, pst);
        end
        if (exp_rd >= 0) check("mem_read_cycles", rd_cnt, exp_rd);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("reset_async", {o_state, outvec}, {4'd0, 16'h0000});
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_to_fetch", o_state, 4'd1);
    endtask

    task automatic check_absorb(input int cycles);
        opcode = 7'b0110011; mem_ready = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #2;
            check("fault_absorb", {o_state, outvec}, {4'd15, 16'h0001});
        end
    endtask

    logic [3:0]  seq_st[6] = '{4'd0, 4'd1, 4'd2, 4'd7, 4'd9, 4'd1};
    logic [15:0] seq_ov[6] = '{16'h0000, 16'h9888, 16'h0140, 16'h0220, 16'h0402, 16'h9888};

    initial begin
        bit found;
        rst_n = 1'b1; opcode = '0; funct3 = '0; funct7_5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {o_state, outvec}, {4'd0, 16'h0000});

        // R-type straight out of reset
        opcode = 7'b0110011;
        scb.push_back(mk(4'd9, 1'b1, 1'b0, 2'b00, 1'b0, 4));
        rst_n = 1'b1;
        #1;
        check("seq_r_0", {o_state, outvec}, {seq_st[0], seq_ov[0]});
        for (int i = 1; i < 6; i++) begin
            @(posedge clk); #2;
            check("seq_r", {o_state, outvec}, {seq_st[i], seq_ov[i]});
        end

        run_instr(7'b0010011, 3'b000, 1'b0, 4'hE, 0, mk(4'd9, 1'b1, 1'b0, 2'b00, 1'b0, 4), 4'd8, 16'h0260, -1);
        run_instr(7'b0110111, 3'b000, 1'b0, 4'hE, 0, mk(4'd9, 1'b1, 1'b0, 2'b00, 1'b0, 4), 4'd12, 16'h0340, -1);
        run_instr(7'b1101111, 3'b000, 1'b0, 4'hE, 0, mk(4'd9, 1'b1, 1'b0, 2'b00, 1'b0, 4), 4'd11, 16'h0980, -1);
        run_instr(7'b0100011, 3'b010, 1'b0, 4'hE, 0, mk(4'd6, 1'b0, 1'b0, 2'b00, 1'b1, 4), 4'd6, 16'hE002, -1);
        // LW with three stall cycles in MEM_READ
        run_instr(7'b0000011, 3'b010, 1'b0, 4'd4, 3, mk(4'd5, 1'b1, 1'b0, 2'b01, 1'b0, 8), 4'd5, 16'h0406, 4);
        run_instr(7'b1100011, 3'b001, 1'b0, 4'hE, 0, mk(4'd10, 1'b0, 1'b1, 2'b00, 1'b0, 3), 4'd10, 16'h0A12, -1);
        run_instr(7'b1100011, 3'b000, 1'b0, 4'hE, 0, mk(4'd10, 1'b0, 1'b0, 2'b00, 1'b0, 3), 4'd10, 16'h0212, -1);
        run_instr(7'b1100011, 3'b000, 1'b1, 4'hE, 0, mk(4'd10, 1'b0, 1'b1, 2'b00, 1'b0, 3), 4'd10, 16'h0A12, -1);

        // illegal opcode
        run_instr(7'b0000000, 3'b000, 1'b0, 4'hE, 0, mk(4'd15, 1'b0, 1'b0, 2'b00, 1'b0, 3), 4'd2, 16'h0140, -1);
        check_absorb(3);
        do_reset();

        // store with funct3 other than word
        run_instr(7'b0100011, 3'b011, 1'b0, 4'hE, 0, mk(4'd15, 1'b0, 1'b0, 2'b00, 1'b0, 4), 4'd3, 16'h0240, -1);
        do_reset();

        // unsupported branch funct3
        run_instr(7'b1100011, 3'b100, 1'b1, 4'hE, 0, mk(4'd15, 1'b0, 1'b0, 2'b00, 1'b0, 4), 4'd10, 16'h0210, -1);
        do_reset();

        // bus never answers in FETCH: 255 wait cycles then FAULT
        run_instr(7'b0110011, 3'b000, 1'b0, 4'd1, 1000, mk(4'd15, 1'b0, 1'b0, 2'b00, 1'b0, 256), 4'd1, 16'h8088, -1);
        check_absorb(3);
        do_reset();

        // reset asserted mid-cycle while a store waits on the bus
        opcode = 7'b0100011; funct3 = 3'b010; mem_ready = 1'b1; found = 0;
        for (int n = 0; n < 10 && !found; n++) begin
            if (n > 0) begin
                @(posedge clk); #1;
            end
            if (o_state == 4'd6) begin
                found = 1;
                mem_ready = 1'b0;
            end
        end
        if (!found) begin
            n_vec++; n_err++;
            $display("FAIL store_reach: state %0d, expected 6", o_state);
        end
        #1;
        check("mem_write_wait", {o_state, outvec}, {4'd6, 16'hE000});
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_mid_write", {o_state, outvec}, {4'd0, 16'h0000});
        @(posedge clk); #2;
        check("scoreboard_drain", scb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
